// File: rtl/cpu_div_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU sequencer.
package cpu_div_pkg;

    // Default operand/result width of the integer divider.
    localparam int DIV_WIDTH = 32;

    // Step counter width: must hold WIDTH-1, with one spare bit of headroom.
    function automatic int div_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int DIV_CNT_WIDTH = div_cnt_width(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_restoring_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference when it is non-negative.
module div_restoring_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] trial_s;

    // Trial subtract one bit wider than the remainder so a borrow shows up in the MSB.
    always_comb begin
        shifted_s = {rem, dividend_msb};
        trial_s   = shifted_s - {2'b00, divisor};
        if (trial_s[WIDTH+1] == 1'b0) begin
            rem_next = trial_s[WIDTH:0];
            q_bit    = 1'b1;
        end else begin
            rem_next = shifted_s[WIDTH:0];
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// DIV/DIVU sequencer beside EX: runs an iterative restoring divider on operand
// magnitudes, stalls the pipeline while it works, and pulses the HI/LO write
// with sign-corrected results in a single DONE cycle.
module div_seq_ctrl
    import cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi_d,
    output logic [WIDTH-1:0] lo_d
);

    localparam int CNT_W = div_cnt_width(WIDTH);

    div_state_e       state_r;
    div_state_e       state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] dq_r;       // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_r;
    logic             neg_q_r;
    logic             neg_rem_r;

    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH-1:0] q_fix_s;
    logic [WIDTH-1:0] r_fix_s;
    logic [WIDTH:0]   rem_next_s;
    logic             q_bit_s;
    logic             load_s;
    logic             step_s;

    div_restoring_step #(.WIDTH(WIDTH)) u_step (
        .rem          (rem_r),
        .dividend_msb (dq_r[WIDTH-1]),
        .divisor      (dvs_r),
        .rem_next     (rem_next_s),
        .q_bit        (q_bit_s)
    );

    // Operand magnitudes; only signed operations treat the MSB as a sign.
    always_comb begin
        a_neg_s = is_signed & a[WIDTH-1];
        b_neg_s = is_signed & b[WIDTH-1];
        if (a_neg_s) begin
            a_mag_s = ~a + WIDTH'(1);
        end else begin
            a_mag_s = a;
        end
        if (b_neg_s) begin
            b_mag_s = ~b + WIDTH'(1);
        end else begin
            b_mag_s = b;
        end
    end

    // Sign correction of the finished magnitudes; -2^(W-1)/-1 wraps naturally.
    always_comb begin
        if (neg_q_r) begin
            q_fix_s = ~dq_r + WIDTH'(1);
        end else begin
            q_fix_s = dq_r;
        end
        if (neg_rem_r) begin
            r_fix_s = ~rem_r[WIDTH-1:0] + WIDTH'(1);
        end else begin
            r_fix_s = rem_r[WIDTH-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state and outputs; cancel wins over everything and drops stall at once.
    always_comb begin
        state_next_s = state_r;
        stall        = 1'b0;
        busy         = 1'b0;
        hilo_we      = 1'b0;
        hi_d         = '0;
        lo_d         = '0;
        load_s       = 1'b0;
        step_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && !cancel) begin
                    load_s       = 1'b1;
                    stall        = 1'b1;
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (cancel) begin
                    state_next_s = IDLE;
                end else begin
                    stall  = 1'b1;
                    step_s = 1'b1;
                    if (cnt_r == CNT_W'(WIDTH - 1)) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = BUSY;
                    end
                end
            end
            DONE: begin
                busy         = 1'b1;
                state_next_s = IDLE;
                if (!cancel) begin
                    hilo_we = 1'b1;
                    hi_d    = r_fix_s;
                    lo_d    = q_fix_s;
                end else begin
                    hilo_we = 1'b0;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Datapath: capture operands on issue, then one restoring step per BUSY cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= '0;
            rem_r     <= '0;
            dq_r      <= '0;
            dvs_r     <= '0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
        end else if (load_s) begin
            cnt_r     <= '0;
            rem_r     <= '0;
            dq_r      <= a_mag_s;
            dvs_r     <= b_mag_s;
            neg_q_r   <= a_neg_s ^ b_neg_s;
            neg_rem_r <= a_neg_s;
        end else if (step_s) begin
            cnt_r     <= cnt_r + CNT_W'(1);
            rem_r     <= rem_next_s;
            dq_r      <= {dq_r[WIDTH-2:0], q_bit_s};
        end
    end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Sequencer for the CPU's multi-cycle DIV/DIVU instruction.
- Runs an iterative restoring divider, one quotient bit per cycle.
- Drives the pipeline stall line, which gates the enables of the stage registers.
- Drives the write-enable and data of the HI/LO register pair. Sits beside the EX stage.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be ≥ 2.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  EX stage holds a DIV/DIVU this cycle; sampled only in IDLE
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- cancel  in  1  exception/flush from later stage; aborts any operation
- a  in  WIDTH  dividend; sampled with start
- b  in  WIDTH  divisor; sampled with start
- stall  out  1  freeze request; pipeline registers hold while high
- busy  out  1  high in BUSY and DONE
- hilo_we  out  1  one-cycle write strobe for HI and LO
- hi_d  out  WIDTH  remainder, valid when hilo_we = 1
- lo_d  out  WIDTH  quotient, valid when hilo_we = 1

Behaviour:
- Reset (async, any state):
  - state = IDLE; counter, quotient and remainder registers = 0.
  - stall = 0, busy = 0, hilo_we = 0, hi_d = 0, lo_d = 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start=1 and cancel=0: capture |a|, |b| (unsigned magnitudes), result-sign flags and is_signed; clear remainder; counter = 0; go to BUSY.
  - stall = start & ~cancel combinationally, so the issuing instruction holds in EX from its first cycle.
- BUSY:
  - Each cycle performs one restoring step: shift {rem, dividend} left by 1; trial = rem − divisor; if trial is non-negative, rem = trial and the shifted-in quotient bit = 1, else 0.
  - counter increments each cycle; after WIDTH steps (counter == WIDTH−1 this cycle), go to DONE.
  - stall = 1.
- DONE (exactly one cycle):
  - stall = 0, hilo_we = 1, hi_d/lo_d hold the final sign-corrected results.
  - The pipeline advances on the same edge that HI/LO latch.
  - Next state IDLE.
- Latency: start sampled at edge 0 → DONE occupies cycle WIDTH+1 → stall high for WIDTH+1 cycles total.
- Sign rules (signed only):
  - Quotient negated iff sign(a) ≠ sign(b).
  - Remainder takes the sign of a.
  - Negation is two's complement at WIDTH bits, applied combinationally in DONE.
- Overflow: signed −2^(WIDTH−1) / −1 → lo = 0x80000000, hi = 0 (WIDTH=32). No trap. Falls out of the magnitude arithmetic; no special case needed.
- Divide by zero:
  - Takes the full latency with no early exit.
  - Result is lo = all ones (magnitude), hi = |a|, then the sign rules apply.
  - Deterministic; the software-visible value is architecturally undefined.
- cancel:
  - In BUSY or DONE: next state IDLE; hilo_we forced 0 in that cycle; stall drops the same cycle.
  - In IDLE: suppresses start.
- start outside IDLE: ignored. The pipeline is frozen, so a repeat start is the same held instruction.
- Back-to-back: after DONE→IDLE, a start in the following cycle begins a new operation normally.
- Widths: remainder register WIDTH+1 bits for the trial subtract; counter $clog2(WIDTH)+1 bits.

Decomposition:
- Shared package cpu_div_pkg holds:
  - state enum {IDLE, BUSY, DONE};
  - DIV_WIDTH = 32;
  - the counter-width localparam.
- One sub-module: div_restoring_step.
  - Purely combinational.
  - Inputs: rem, dividend MSB, divisor. Outputs: next rem, quotient bit.
  - Instantiated once and used every BUSY cycle.
- FSM, counter, sign handling and output registers stay in div_seq_ctrl.

Test Plan:
- Unsigned: DIVU a=100, b=7 → stall high 33 cycles, then hilo_we pulse with lo=14, hi=2; stall low in the hilo_we cycle.
- Signed: DIV a=−7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=7, b=−2 → lo=0xFFFFFFFD, hi=1.
- Overflow and zero divisor:
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU a=5, b=0 → lo=0xFFFFFFFF, hi=5, same 33-cycle latency.
- cancel asserted on cycle 10 of BUSY → stall low that cycle, no hilo_we pulse, state IDLE; next start 2 cycles later completes correctly.
- rst asserted asynchronously mid-BUSY → all outputs 0 immediately without waiting for a clock edge; no hilo_we before the next start.
- Back-to-back: two DIVUs (100/7 then 81/9) with start re-asserted the cycle after DONE → two hilo_we pulses 34 cycles apart with (lo=14, hi=2) and then (lo=9, hi=0).
